// File: rtl/sound_mix_matrix.sv
// sound_mix_matrix
// Runtime-programmable CH_COUNT x OUT_COUNT audio mixing matrix. On each
// SAMPLE_STB the channel inputs are snapshotted. One shared multiplier then
// walks every (output, channel) term, one term per clock. Each output bus
// gets sum(sample * gain) >>> (GAIN_WIDTH-1), saturated to OUT_WIDTH.
//
// Ports
//   CLK         system clock
//   RESET_n     synchronous active-low reset
//   SAMPLE_STB  one-cycle pulse that starts a mixing frame
//   IN          channel samples, ch k at [k*IN_WIDTH +: IN_WIDTH] (signed)
//   GAIN_WE     gain write request
//   GAIN_ADDR   gain entry index = out*CH_COUNT + ch
//   GAIN_DIN    gain value (unsigned, unity = 2^(GAIN_WIDTH-1))
//   GAIN_READY  write port can accept a write
//   OVR_CLR     clears OVERRUN
//   OUT         mixed samples, bus m at [m*OUT_WIDTH +: OUT_WIDTH] (signed)
//   OUT_VALID   one-cycle pulse when OUT updates
//   BUSY        frame in progress
//   OVERRUN     sticky: SAMPLE_STB arrived while BUSY
module sound_mix_matrix #(
  parameter int CH_COUNT   = 4,
  parameter int OUT_COUNT  = 2,
  parameter int IN_WIDTH   = 16,
  parameter int OUT_WIDTH  = 16,
  parameter int GAIN_WIDTH = 8,
  localparam int TERMS  = CH_COUNT * OUT_COUNT,
  localparam int ADDR_W = (TERMS > 1) ? $clog2(TERMS) : 1
) (
  input  logic                           CLK,
  input  logic                           RESET_n,
  input  logic                           SAMPLE_STB,
  input  logic [CH_COUNT*IN_WIDTH-1:0]   IN,
  input  logic                           GAIN_WE,
  input  logic [ADDR_W-1:0]              GAIN_ADDR,
  input  logic [GAIN_WIDTH-1:0]          GAIN_DIN,
  output logic                           GAIN_READY,
  input  logic                           OVR_CLR,
  output logic [OUT_COUNT*OUT_WIDTH-1:0] OUT,
  output logic                           OUT_VALID,
  output logic                           BUSY,
  output logic                           OVERRUN
);

  localparam int CH_W   = (CH_COUNT > 1) ? $clog2(CH_COUNT) : 1;
  localparam int OUT_W  = (OUT_COUNT > 1) ? $clog2(OUT_COUNT) : 1;
  localparam int PROD_W = IN_WIDTH + GAIN_WIDTH + 1;
  localparam int ACC_W  = PROD_W + $clog2(CH_COUNT);

  localparam logic [GAIN_WIDTH-1:0] UNITY     = {1'b1, {(GAIN_WIDTH-1){1'b0}}};
  localparam logic [ADDR_W-1:0]     LAST_TERM = ADDR_W'(TERMS - 1);
  localparam logic [CH_W-1:0]       LAST_CH   = CH_W'(CH_COUNT - 1);

  // Saturation bounds expressed at accumulator width.
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_DONE} state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0]             term_q;
  logic [CH_W-1:0]               ch_q;
  logic [OUT_W-1:0]              out_q;
  logic signed [IN_WIDTH-1:0]    snap_q  [CH_COUNT];
  logic [GAIN_WIDTH-1:0]         gain_q  [TERMS];
  logic signed [ACC_W-1:0]       acc_q;
  logic signed [OUT_WIDTH-1:0]   stage_q [OUT_COUNT];
  logic signed [OUT_WIDTH-1:0]   out_reg_q [OUT_COUNT];
  logic                          valid_q;
  logic                          ovr_q;

  logic                          pend_valid_q;
  logic [ADDR_W-1:0]             pend_addr_q;
  logic [GAIN_WIDTH-1:0]         pend_data_q;

  logic signed [PROD_W-1:0]      product;
  logic signed [ACC_W-1:0]       acc_sum;
  logic signed [ACC_W-1:0]       shifted;
  logic signed [OUT_WIDTH-1:0]   sat_val;
  logic                          last_ch;
  logic                          last_term;
  logic                          busy;
  logic                          wr_ok;

  assign busy      = (state_q != S_IDLE);
  assign last_ch   = (ch_q == LAST_CH);
  assign last_term = (term_q == LAST_TERM);
  assign wr_ok     = GAIN_WE && !pend_valid_q && (32'(GAIN_ADDR) < TERMS);

  // Shared MAC datapath: the term index walks gains in storage order, so
  // the gain entry is selected directly by term_q.
  always_comb begin
    product = PROD_W'(snap_q[ch_q]) * PROD_W'($signed({1'b0, gain_q[term_q]}));
    acc_sum = acc_q + ACC_W'(product);
    shifted = acc_sum >>> (GAIN_WIDTH - 1);
    if (shifted > SAT_MAX)      sat_val = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    else if (shifted < SAT_MIN) sat_val = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    else                        sat_val = shifted[OUT_WIDTH-1:0];
  end

  // NOTE: always_comb assigns every output a default before the case, so no
  // path can leave state_d unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (SAMPLE_STB) state_d = S_MAC;
      S_MAC:   if (last_term)  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (!RESET_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      term_q  <= '0;
      ch_q    <= '0;
      out_q   <= '0;
      acc_q   <= '0;
      valid_q <= 1'b0;
      for (int c = 0; c < CH_COUNT; c++)  snap_q[c] <= '0;
      for (int m = 0; m < OUT_COUNT; m++) begin
        stage_q[m]   <= '0;
        out_reg_q[m] <= '0;
      end
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (SAMPLE_STB) begin
            for (int c = 0; c < CH_COUNT; c++)
              snap_q[c] <= IN[c*IN_WIDTH +: IN_WIDTH];
            acc_q  <= '0;
            term_q <= '0;
            ch_q   <= '0;
            out_q  <= '0;
          end
        end
        S_MAC: begin
          term_q <= term_q + 1'b1;
          if (last_ch) begin
            // Bus complete: bank the saturated result, restart the sum.
            stage_q[out_q] <= sat_val;
            acc_q          <= '0;
            ch_q           <= '0;
            out_q          <= out_q + 1'b1;
          end else begin
            acc_q <= acc_sum;
            ch_q  <= ch_q + 1'b1;
          end
        end
        S_DONE: begin
          for (int m = 0; m < OUT_COUNT; m++) out_reg_q[m] <= stage_q[m];
          valid_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Gain table. While a frame is running, writes are parked so the frame
  // keeps the gains it started with; the parked write lands at DONE.
  // NOTE: the gain table is reset (unlike a plain RAM) because unity gains
  // are an architectural reset value, so it must stay in flops.
  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      for (int i = 0; i < TERMS; i++) gain_q[i] <= UNITY;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      pend_data_q  <= '0;
    end else begin
      case (state_q)
        S_MAC: begin
          if (wr_ok) begin
            pend_valid_q <= 1'b1;
            pend_addr_q  <= GAIN_ADDR;
            pend_data_q  <= GAIN_DIN;
          end
        end
        S_DONE: begin
          // With nothing parked, a write arriving now is past every term of
          // the frame and can commit immediately.
          if (pend_valid_q) begin
            gain_q[pend_addr_q] <= pend_data_q;
            pend_valid_q        <= 1'b0;
          end else if (wr_ok) begin
            gain_q[GAIN_ADDR] <= GAIN_DIN;
          end
        end
        default: begin
          if (wr_ok) gain_q[GAIN_ADDR] <= GAIN_DIN;
        end
      endcase
    end
  end

  // A new overrun wins over a simultaneous clear.
  always_ff @(posedge CLK) begin
    if (!RESET_n)                ovr_q <= 1'b0;
    else if (SAMPLE_STB && busy) ovr_q <= 1'b1;
    else if (OVR_CLR)            ovr_q <= 1'b0;
  end

  for (genvar m = 0; m < OUT_COUNT; m++) begin : g_out
    assign OUT[m*OUT_WIDTH +: OUT_WIDTH] = out_reg_q[m];
  end

  assign OUT_VALID  = valid_q;
  assign BUSY       = busy;
  assign OVERRUN    = ovr_q;
  assign GAIN_READY = !pend_valid_q;

endmodule

// File: doc/sound_mix_matrix.md
# sound_mix_matrix

Runtime-programmable N-input, M-output sound mixing matrix. It generalises the fixed chain of per-source attenuators (compile-time MUL/DIV) and single-bus mixers into one block. Each input channel (MEGAROM, FM, PSG, …) is scaled by a per-(channel, output) gain register and summed into each output bus (external, cartridge-internal, …). A single shared multiplier is time-multiplexed across all terms, once per audio sample strobe.

## Interface
Parameters:
- CH_COUNT, 4, number of input channels (≥1)
- OUT_COUNT, 2, number of output buses (≥1)
- IN_WIDTH, 16, signed input sample width
- OUT_WIDTH, 16, signed output sample width
- GAIN_WIDTH, 8, unsigned gain width; unity = 2^(GAIN_WIDTH-1)

Ports:
- CLK  in  1  system clock; the block uses this single clock
- RESET_n  in  1  reset, synchronous, active-low
- SAMPLE_STB  in  1  one-cycle pulse: start a mixing frame
- IN  in  CH_COUNT*IN_WIDTH  channel samples, ch k at bits [k*IN_WIDTH +: IN_WIDTH]
- GAIN_WE  in  1  gain write request
- GAIN_ADDR  in  clog2(CH_COUNT*OUT_COUNT)  entry index = out*CH_COUNT + ch
- GAIN_DIN  in  GAIN_WIDTH  gain value
- GAIN_READY  out  1  write port can accept a write
- OVR_CLR  in  1  clear OVERRUN
- OUT  out  OUT_COUNT*OUT_WIDTH  mixed samples, bus m at [m*OUT_WIDTH +: OUT_WIDTH]
- OUT_VALID  out  1  one-cycle pulse when OUT updates
- BUSY  out  1  frame in progress
- OVERRUN  out  1  sticky: SAMPLE_STB arrived while BUSY

## Operation
- Reset values: OUT=0, OUT_VALID=0, BUSY=0, GAIN_READY=1, OVERRUN=0, all gain entries = 2^(GAIN_WIDTH-1) (unity), pending-write slot empty.
- States: IDLE, MAC, DONE.
- IDLE: SAMPLE_STB=1 → latch all IN into a snapshot, clear the accumulator, term index=0, go to MAC.
- MAC: one term per cycle, N = CH_COUNT*OUT_COUNT terms.
  - Order: out0 ch0..ch(C-1), then out1, and so on.
  - acc += signed(snapshot[ch]) * unsigned(gain[out][ch]).
  - On the last channel of each output: result = acc >>> (GAIN_WIDTH-1) (arithmetic, floor), saturated to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1], stored in a staging register. The accumulator then clears.
  - After term N-1 → DONE.
- DONE: all staging registers copied to OUT simultaneously, OUT_VALID=1 for one cycle, return to IDLE.
- Accumulator width: IN_WIDTH+GAIN_WIDTH+1+clog2(CH_COUNT); no internal overflow is possible.
- Gain writes:
  - Accepted when GAIN_WE && GAIN_READY.
  - If IDLE and no DONE this cycle: the entry is written at that edge.
  - Otherwise the write is parked in a single pending slot and GAIN_READY=0 from the next cycle. The pending write commits on the DONE edge and GAIN_READY returns to 1.
  - A frame always uses gains as they stood at its SAMPLE_STB edge.
  - GAIN_WE while GAIN_READY=0 is ignored.
  - An out-of-range GAIN_ADDR is ignored.
- Overrun: SAMPLE_STB while BUSY=1 (MAC or DONE) is dropped and sets OVERRUN. The frame in flight is unaffected.
  - OVR_CLR clears OVERRUN.
  - Simultaneous OVR_CLR and a new overrun → OVERRUN=1.
- Reset mid-frame: the frame is abandoned and all outputs take their reset values. The pending write is discarded and gains return to unity.

## Timing
- Strobe sampled at edge E0 (IDLE) → BUSY=1 after E0.
- MAC terms occur at edges E1..EN.
- DONE at edge EN+1: OUT and OUT_VALID=1 visible after EN+1; BUSY=0 after EN+1.
- Latency strobe→OUT_VALID = N+1 cycles. Minimum strobe period = N+2 cycles.
- IN needs to be stable only on the E0 edge.
- GAIN_READY drops the cycle after a parked write and rises after the DONE edge.

## Test plan
Configuration: CH=4, OUT=2, IN=OUT=16, G=8, unity=128.
- Reset, then IN={1000,2000,-500,0}, strobe → OUT_VALID exactly 9 cycles after the strobe edge; both buses = 2500. BUSY is high for cycles 1..9 only.
- Saturation: all inputs 30000 → both buses 32767; all inputs -30000 → -32768. No wrap.
- Gain write idle: entry 4 (out1, ch0) = 64; IN={1001,0,0,0} → out0=1001, out1=500. IN ch0=-1001 → out1=-501 (floor). Gain 0 → 0; gain 255 on 20000 → 32767.
- Write during frame: write entry 0=0 two cycles after a strobe.
  - GAIN_READY=0 until DONE.
  - The current frame uses unity; the next frame gives out0 = sum of ch1..ch3 only.
  - A second write while not ready is ignored.
- Overrun/reset: strobe at cycle 3 of a frame → OVERRUN=1 and the current results are unchanged. OVR_CLR → 0. RESET_n low at cycle 5 of a frame → OUT=0, BUSY=0, no OUT_VALID, gains back to 128.
